// File: rtl/alu_rr_scheduler.sv
// -----------------------------------------------------------------------------
// alu_rr_scheduler
//   Shares one registered ALU among NREQ requesters. A round-robin arbiter picks
//   one requester at a time; its operands are latched onto the ALU inputs, the
//   scheduler waits out the ALU latency, captures the result and returns it as a
//   tagged response. Only one operation is ever in flight.
//
// Ports
//   clk, reset      clock (rising edge), asynchronous active-high reset
//   req_valid/ready per-requester handshake; ready is one-hot or zero, IDLE only
//   req_a/b/op      packed operands, requester i at [i*WIDTH +: WIDTH] etc.
//   rsp_valid/ready response handshake
//   rsp_id/y/co     owner index and captured ALU result/carry
//   alu_*_in        driven to the ALU, hold last granted values
//   alu_y/co_out    returned by the ALU
//   busy            high whenever an operation is in progress
// -----------------------------------------------------------------------------
module alu_rr_scheduler #(
    parameter int WIDTH   = 8,
    parameter int OPCODE  = 4,
    parameter int NREQ    = 4,
    parameter int ALU_LAT = 1,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WIDTH-1:0]    req_a,
    input  logic [NREQ*WIDTH-1:0]    req_b,
    input  logic [NREQ*OPCODE-1:0]   req_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_y,
    output logic                     rsp_co,
    output logic [WIDTH-1:0]         alu_a_in,
    output logic [WIDTH-1:0]         alu_b_in,
    output logic [OPCODE-1:0]        alu_opcode_in,
    input  logic [WIDTH-1:0]         alu_y_out,
    input  logic                     alu_co_out,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   id;
    logic [3:0]       cnt;

    logic             any_valid;
    logic             hi_found;
    logic [IDW-1:0]   hi_win;
    logic [IDW-1:0]   lo_win;
    logic [IDW-1:0]   win;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [OPCODE-1:0] sel_op;

    // Round-robin search split into two priority scans: the lowest valid index
    // at or above ptr wins; failing that, the lowest valid index overall
    // (the wrap-around part). Works for any NREQ, power of two or not.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        any_valid = 1'b0;
        hi_found  = 1'b0;
        hi_win    = '0;
        lo_win    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any_valid = 1'b1;
                lo_win    = IDW'(i);
                if (i >= int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_win   = IDW'(i);
                end
            end
        end
        win = hi_found ? hi_win : lo_win;
    end

    // Operand mux for the current winner.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                sel_a  = req_a[i*WIDTH +: WIDTH];
                sel_b  = req_b[i*WIDTH +: WIDTH];
                sel_op = req_op[i*OPCODE +: OPCODE];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples pre-edge values regardless of block ordering.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_valid)        state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0)      state_nxt = RESP;
            RESP:    if (rsp_ready)        state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state. rsp_valid is exactly "in RESP", which is
    // registered state, so it is glitch-free.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (state == IDLE) && any_valid && (win == IDW'(i));
        end
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    // Datapath: grant capture, latency counter, result capture, pointer update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr           <= '0;
            id            <= '0;
            cnt           <= '0;
            alu_a_in      <= '0;
            alu_b_in      <= '0;
            alu_opcode_in <= '0;
            rsp_id        <= '0;
            rsp_y         <= '0;
            rsp_co        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_valid) begin
                        alu_a_in      <= sel_a;
                        alu_b_in      <= sel_b;
                        alu_opcode_in <= sel_op;
                        id            <= win;
                        cnt           <= 4'(ALU_LAT);
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_y  <= alu_y_out;
                        rsp_co <= alu_co_out;
                        rsp_id <= id;
                    end
                end
                RESP: begin
                    // The requester just served drops to lowest priority.
                    if (rsp_ready) begin
                        ptr <= (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
module tb_alu_rr_scheduler;

    localparam int W   = 8;
    localparam int OPC = 4;
    localparam int N   = 4;
    localparam int LAT = 1;
    localparam int IDW = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*W-1:0]     req_a;
    logic [N*W-1:0]     req_b;
    logic [N*OPC-1:0]   req_op;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [W-1:0]       rsp_y;
    logic               rsp_co;
    logic [W-1:0]       alu_a_in;
    logic [W-1:0]       alu_b_in;
    logic [OPC-1:0]     alu_opcode_in;
    logic [W-1:0]       alu_y_out;
    logic               alu_co_out;
    logic               busy;

    logic [W-1:0]       a_v  [N];
    logic [W-1:0]       b_v  [N];
    logic [OPC-1:0]     op_v [N];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ptr_m = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W]     = a_v[i];
            req_b[i*W +: W]     = b_v[i];
            req_op[i*OPC +: OPC] = op_v[i];
        end
    end

    // ALU stub, one register stage: y = a + b, co = carry, opcode ignored.
    always_ff @(posedge clk) begin
        {alu_co_out, alu_y_out} <= {1'b0, alu_a_in} + {1'b0, alu_b_in};
    end

    alu_rr_scheduler #(
        .WIDTH(W), .OPCODE(OPC), .NREQ(N), .ALU_LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_co(rsp_co),
        .alu_a_in(alu_a_in), .alu_b_in(alu_b_in), .alu_opcode_in(alu_opcode_in),
        .alu_y_out(alu_y_out), .alu_co_out(alu_co_out),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arbiter: first valid requester scanning from p upward, wrapping.
    function automatic int winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (((v >> idx) & N'(1)) != '0) return idx;
        end
        return -1;
    endfunction

    // One complete operation, entered at a negedge with the DUT in IDLE and
    // req_valid already set. Returns the cycle stamp of the grant edge.
    task automatic run_op(input string nm, input int stall, output int gcyc, output int gid);
        int g, n;
        logic [W:0] sum;
        g   = winner(req_valid, ptr_m);
        gid = g;
        sum = {1'b0, a_v[g]} + {1'b0, b_v[g]};
        #1;
        check({nm, "_ready"}, 32'(req_ready), 32'(1 << g));
        check({nm, "_busy_idle"}, 32'(busy), 32'(0));
        @(negedge clk);
        gcyc = cyc;
        req_valid = req_valid & ~(N'(1) << g);
        check({nm, "_alu_a"}, 32'(alu_a_in), 32'(a_v[g]));
        check({nm, "_alu_b"}, 32'(alu_b_in), 32'(b_v[g]));
        check({nm, "_alu_op"}, 32'(alu_opcode_in), 32'(op_v[g]));
        check({nm, "_ready_wait"}, 32'(req_ready), 32'(0));
        check({nm, "_busy"}, 32'(busy), 32'(1));
        n = 1;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_latency"}, 32'(n), 32'(LAT + 2));
        check({nm, "_id"}, 32'(rsp_id), 32'(g));
        check({nm, "_y"}, 32'(rsp_y), 32'(sum[W-1:0]));
        check({nm, "_co"}, 32'(rsp_co), 32'(sum[W]));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({nm, "_hold_valid"}, 32'(rsp_valid), 32'(1));
            check({nm, "_hold_y"}, 32'({rsp_id, rsp_co, rsp_y}), 32'({IDW'(g), sum[W], sum[W-1:0]}));
            check({nm, "_hold_ready"}, 32'(req_ready), 32'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({nm, "_rsp_done"}, 32'(rsp_valid), 32'(0));
        check({nm, "_busy_done"}, 32'(busy), 32'(0));
        ptr_m = (g + 1) % N;
    endtask

    initial begin
        int gc, gid, prev_gc;
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            a_v[i] = '0; b_v[i] = '0; op_v[i] = OPC'(i + 3);
        end
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_ready", 32'(req_ready), 32'(0));
        check("rst_rsp", 32'({rsp_valid, rsp_id, rsp_y, rsp_co}), 32'(0));
        check("rst_alu", 32'({alu_a_in, alu_b_in, alu_opcode_in}), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        reset = 1'b0;
        @(negedge clk);

        // Single requester, no carry.
        a_v[0] = 8'h12; b_v[0] = 8'h34; req_valid = 4'b0001;
        run_op("single", 0, gc, gid);

        // Carry out from requester 2.
        a_v[2] = 8'hFF; b_v[2] = 8'h01; req_valid = 4'b0100;
        run_op("carry", 0, gc, gid);
        check("carry_who", 32'(gid), 32'(2));

        // Fairness: after 2 is served, 3 goes before 1.
        a_v[1] = 8'h80; b_v[1] = 8'h80; a_v[3] = 8'h0F; b_v[3] = 8'h01;
        req_valid = 4'b1010;
        run_op("fair_a", 0, gc, gid);
        check("fair_first", 32'(gid), 32'(3));
        run_op("fair_b", 0, gc, gid);
        check("fair_second", 32'(gid), 32'(1));

        // Fresh reset, all four valid: order 0,1,2,3 at minimum op period.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ptr_m = 0;
        for (int i = 0; i < N; i++) begin
            a_v[i] = W'($urandom); b_v[i] = W'($urandom);
        end
        req_valid = 4'b1111;
        prev_gc = 0;
        for (int i = 0; i < N; i++) begin
            run_op("order", 0, gc, gid);
            check("order_id", 32'(gid), 32'(i));
            if (i > 0) check("order_period", 32'(gc - prev_gc), 32'(LAT + 3));
            prev_gc = gc;
        end

        // Backpressure with every other requester waiting.
        req_valid = 4'b1111;
        run_op("bp", 5, gc, gid);
        req_valid = '0;

        // Randomized traffic.
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N; i++) begin
                a_v[i]  = W'($urandom);
                b_v[i]  = W'($urandom);
                op_v[i] = OPC'($urandom);
            end
            req_valid = N'($urandom_range(1, (1 << N) - 1));
            run_op("rand", int'($urandom_range(0, 2)), gc, gid);
            req_valid = '0;
        end

        // Reset during WAIT: op dropped, pointer back to 0.
        req_valid = 4'b0001;
        run_op("pre_rst", 0, gc, gid);
        req_valid = 4'b1111;
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'(1));
        reset     = 1'b1;
        req_valid = '0;
        #1;
        check("mid_rsp", 32'({rsp_valid, rsp_id, rsp_y, rsp_co}), 32'(0));
        check("mid_alu", 32'({alu_a_in, alu_b_in, alu_opcode_in}), 32'(0));
        check("mid_ctl", 32'({busy, req_ready}), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_no_rsp", 32'({rsp_valid, busy}), 32'(0));
        end
        ptr_m = 0;
        req_valid = 4'b1111;
        run_op("post_rst", 0, gc, gid);
        check("post_rst_ptr", 32'(gid), 32'(0));
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
